// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Turns the core's level-sensitive single-request memory handshake into APB
//   master transfers (SETUP -> ACCESS) and returns a one-cycle acknowledge,
//   registered read data and a timeout error flag. A PREADY watchdog aborts
//   the ACCESS phase after TIMEOUT cycles so a dead slave cannot hang the core.
//
// Ports
//   clk, reset          : system clock (rising edge), async active-low reset
//   S_MEM_ADDR/WDATA/WE : request operands, latched when the request is taken
//   S_REQ               : request level, held by the core until S_ACK
//   S_ACK / S_ERR       : one-cycle completion pulse / timed-out qualifier
//   S_RDATA             : last completed read data (ERR_DATA after an abort)
//   S_BUSY              : transfer in flight
//   M_P*                : APB master port
//
// state  | meaning
// IDLE   | no transfer; takes a new request when not acknowledging
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waiting for PREADY or the watchdog
module apb_master_bridge #(
  parameter int                   BUS_WIDTH = 16,
  parameter int                   TIMEOUT   = 16,
  parameter int                   CNT_WIDTH = 8,
  parameter logic [BUS_WIDTH-1:0] ERR_DATA  = 16'hDEAD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_MEM_ADDR,
  input  logic [BUS_WIDTH-1:0] S_MEM_WDATA,
  input  logic                 S_MEM_WE,
  input  logic                 S_REQ,
  output logic                 S_ACK,
  output logic [BUS_WIDTH-1:0] S_RDATA,
  output logic                 S_ERR,
  output logic                 S_BUSY,
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit                   WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 ack_q, ack_nxt;
  logic                 err_q, err_nxt;
  logic                 busy_q;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_nxt;
  logic [BUS_WIDTH-1:0] paddr_q, paddr_nxt;
  logic [BUS_WIDTH-1:0] pwdata_q, pwdata_nxt;
  logic                 pwrite_q, pwrite_nxt;
  logic                 psel_q, psel_nxt;
  logic                 pen_q, pen_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      busy_q   <= (state_nxt != IDLE);
      rdata_q  <= rdata_nxt;
      paddr_q  <= paddr_nxt;
      pwdata_q <= pwdata_nxt;
      pwrite_q <= pwrite_nxt;
      psel_q   <= psel_nxt;
      pen_q    <= pen_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    rdata_nxt  = rdata_q;
    paddr_nxt  = paddr_q;
    pwdata_nxt = pwdata_q;
    pwrite_nxt = pwrite_q;
    psel_nxt   = psel_q;
    pen_nxt    = pen_q;
    case (state)
      IDLE: begin
        psel_nxt = 1'b0;
        pen_nxt  = 1'b0;
        // The core still has S_REQ high during the ACK cycle; ignore it there.
        if (!ack_q && S_REQ) begin
          paddr_nxt  = S_MEM_ADDR;
          pwdata_nxt = S_MEM_WDATA;
          pwrite_nxt = S_MEM_WE;
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        pen_nxt   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over a watchdog expiry on the same edge.
        if (M_PREADY) begin
          psel_nxt  = 1'b0;
          pen_nxt   = 1'b0;
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
          if (!pwrite_q) rdata_nxt = M_PRDATA;
        end else if (WDOG_EN && (cnt == CNT_LAST)) begin
          psel_nxt  = 1'b0;
          pen_nxt   = 1'b0;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          if (!pwrite_q) rdata_nxt = ERR_DATA;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign S_ACK     = ack_q;
  assign S_ERR     = err_q;
  assign S_BUSY    = busy_q;
  assign S_RDATA   = rdata_q;
  assign M_PADDR   = paddr_q;
  assign M_PWDATA  = pwdata_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = pen_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] S_MEM_ADDR = '0;
  logic [15:0] S_MEM_WDATA = '0;
  logic        S_MEM_WE = 1'b0;
  logic        S_REQ = 1'b0;
  logic        S_ACK;
  logic [15:0] S_RDATA;
  logic        S_ERR;
  logic        S_BUSY;
  logic [15:0] M_PADDR;
  logic        M_PWRITE;
  logic        M_PSELx;
  logic        M_PENABLE;
  logic [15:0] M_PWDATA;
  logic [15:0] M_PRDATA = '0;
  logic        M_PREADY = 1'b0;

  apb_master_bridge #(
    .BUS_WIDTH(16), .TIMEOUT(16), .CNT_WIDTH(8), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .reset(reset),
    .S_MEM_ADDR(S_MEM_ADDR), .S_MEM_WDATA(S_MEM_WDATA), .S_MEM_WE(S_MEM_WE),
    .S_REQ(S_REQ), .S_ACK(S_ACK), .S_RDATA(S_RDATA), .S_ERR(S_ERR), .S_BUSY(S_BUSY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] prdata;
    int          waits;
    int          lat;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          req_cyc;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int psel_cnt = 0;
  int pen_cnt = 0;
  int access_n = 0;
  int cur_waits = 0;
  logic        cur_we = 1'b0;
  logic [15:0] cur_addr = '0;
  logic [15:0] cur_wdata = '0;
  logic [15:0] cur_prdata = '0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Slave model plus operand-stability checks while the bus is selected.
  always @(negedge clk) begin
    if (M_PSELx && M_PENABLE) access_n++;
    else access_n = 0;
    if (M_PSELx) begin
      psel_cnt++;
      check(M_PADDR == cur_addr, "paddr_stable", M_PADDR, cur_addr);
      check(M_PWRITE == cur_we, "pwrite_stable", M_PWRITE, cur_we);
      if (cur_we) check(M_PWDATA == cur_wdata, "pwdata_stable", M_PWDATA, cur_wdata);
    end
    if (M_PENABLE) pen_cnt++;
    M_PREADY = M_PENABLE && (access_n > cur_waits);
    M_PRDATA = cur_prdata;
  end

  // Scoreboard: every S_ACK consumes one expected completion.
  always @(negedge clk) begin
    check(!(S_ERR && !S_ACK), "err_without_ack", S_ERR, 0);
    if (S_ACK) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(S_ERR == e.err, "ack_err", S_ERR, e.err);
        check(S_RDATA == e.rdata, "ack_rdata", S_RDATA, e.rdata);
        check((cyc - e.req_cyc) == e.lat, "ack_latency", cyc - e.req_cyc, e.lat);
      end
    end
  end

  task automatic start_txn(input vec_t v, input int lat);
    exp_t e;
    S_MEM_ADDR  = v.addr;
    S_MEM_WDATA = v.wdata;
    S_MEM_WE    = v.we;
    S_REQ       = 1'b1;
    cur_addr    = v.addr;
    cur_wdata   = v.wdata;
    cur_we      = v.we;
    cur_prdata  = v.prdata;
    cur_waits   = v.waits;
    psel_cnt    = 0;
    pen_cnt     = 0;
    e.err = v.err;
    e.rdata = v.rdata;
    e.lat = lat;
    e.req_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic finish_txn(input int exp_psel, input bit keep_req);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (S_ACK) begin
        seen = 1'b1;
        break;
      end
    end
    check(seen, "ack_timeout", seen, 1);
    if (!keep_req) S_REQ = 1'b0;
    check(psel_cnt == exp_psel, "psel_cycles", psel_cnt, exp_psel);
    check(pen_cnt == exp_psel - 1, "penable_cycles", pen_cnt, exp_psel - 1);
    check(!M_PSELx && !M_PENABLE, "bus_idle_at_ack", {M_PSELx, M_PENABLE}, 0);
    check(!S_BUSY, "busy_at_ack", S_BUSY, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({S_ACK, S_ERR, S_BUSY, M_PSELx, M_PENABLE, M_PWRITE} == '0, name, {S_ACK, S_ERR, S_BUSY, M_PSELx, M_PENABLE, M_PWRITE}, 0);
    check({S_RDATA, M_PADDR, M_PWDATA} == '0, {name, "_data"}, {S_RDATA, M_PADDR, M_PWDATA}, 0);
  endtask

  initial begin
    vec_t b;
    //        we    addr      wdata     prdata    waits lat err   rdata
    vecs[0] = '{1'b1, 16'h0084, 16'h1234, 16'h0000, 0,   3,  1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0090, 16'h0000, 16'hBEEF, 3,   6,  1'b0, 16'hBEEF};
    vecs[2] = '{1'b0, 16'h00A0, 16'h0000, 16'h5555, 255, 18, 1'b1, 16'hDEAD};
    vecs[3] = '{1'b1, 16'h00B0, 16'h7777, 16'h0000, 255, 18, 1'b1, 16'hDEAD};
    vecs[4] = '{1'b0, 16'h00C0, 16'h0000, 16'hA5A5, 15,  18, 1'b0, 16'hA5A5};
    vecs[5] = '{1'b0, 16'h00D0, 16'h0000, 16'hC3C3, 14,  17, 1'b0, 16'hC3C3};
    vecs[6] = '{1'b1, 16'h00E0, 16'h4242, 16'h0000, 1,   4,  1'b0, 16'hC3C3};

    // Reset held with a pending request: nothing may move.
    S_MEM_ADDR = vecs[0].addr;
    S_MEM_WDATA = vecs[0].wdata;
    S_MEM_WE = 1'b1;
    S_REQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(!M_PSELx, "psel_in_reset", M_PSELx, 0);
    end
    check_all_zero("reset_outputs");

    // Release: SETUP one edge later.
    start_txn(vecs[0], vecs[0].lat);
    reset = 1'b1;
    @(negedge clk);
    check(M_PSELx && !M_PENABLE && S_BUSY, "setup_after_release", {M_PSELx, M_PENABLE, S_BUSY}, 3'b101);
    finish_txn(vecs[0].lat - 1, 1'b0);

    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      start_txn(vecs[i], vecs[i].lat);
      finish_txn(vecs[i].lat - 1, 1'b0);
    end

    // Back-to-back: S_REQ stays high through the ACK cycle.
    @(negedge clk);
    b = '{1'b1, 16'h0100, 16'h1111, 16'h0000, 0, 3, 1'b0, 16'hC3C3};
    start_txn(b, 3);
    finish_txn(2, 1'b1);
    b = '{1'b1, 16'h0102, 16'h2222, 16'h0000, 0, 4, 1'b0, 16'hC3C3};
    start_txn(b, 4);
    @(negedge clk);
    check(!M_PSELx && !S_BUSY, "no_setup_in_ack_cycle", {M_PSELx, S_BUSY}, 0);
    finish_txn(2, 1'b0);

    // Asynchronous reset during a wait state.
    @(negedge clk);
    b = '{1'b0, 16'h00F0, 16'h0000, 16'h9999, 255, 18, 1'b0, 16'h0000};
    start_txn(b, 18);
    repeat (5) @(negedge clk);
    check(M_PENABLE, "in_access_before_reset", M_PENABLE, 1);
    #2 reset = 1'b0;
    #1;
    check(!M_PSELx && !M_PENABLE && !S_BUSY, "async_reset_drop", {M_PSELx, M_PENABLE, S_BUSY}, 0);
    void'(sb.pop_front());
    S_REQ = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset_outputs");
    reset = 1'b1;
    @(negedge clk);
    check(!S_ACK && !M_PSELx, "no_ack_after_abort", {S_ACK, M_PSELx}, 0);

    b = '{1'b0, 16'h00F4, 16'h0000, 16'h1357, 2, 5, 1'b0, 16'h1357};
    start_txn(b, 5);
    finish_txn(4, 1'b0);
    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
